pipeline_stage_fifo: RTL and testbench
======================================

Name: pipeline_stage_fifo

Overview:
- Parametrised successor to the single-skid pipeline stage: one output register plus a DEPTH-entry in-order skid FIFO.
- Absorbs bursts while downstream is stalled and propagates flush one stage per cycle.
- Asserts an early stall upstream at a programmable occupancy threshold.
- Reports occupancy and overflow drops.
- Instantiated between pipeline stages in the datapath; chains directly (out_* of one stage to in_* of the next, out_stall to the upstream in_stall).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 4, skid FIFO entries; power of two, >= 2.
- STALL_THRESH, DEPTH-1, out_stall asserts when occupancy >= STALL_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_flush  input  1  flush request from upstream.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_stall  input  1  downstream stall.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_flush  output  1  registered flush to downstream.
- out_stall  output  1  stall to upstream.
- occupancy  output  $clog2(DEPTH+1)  FIFO entry count, registered.
- drop  output  1  one-cycle pulse: an input beat was discarded because the FIFO was full.

Behaviour:
- Reset (async, active-high): out_data=0, out_valid=0, out_flush=0, occupancy=0, drop=0. FIFO pointers cleared. Reset mid-burst discards all contents.
- Output register "advance" condition: adv = !(out_valid & in_stall). When adv=0, out_data and out_valid hold their values.
- When adv=1, the output register loads from the first matching source:
  - FIFO non-empty: load the FIFO head (dequeue), out_valid<=1.
  - FIFO empty and in_valid=1: load in_data directly (bypass), out_valid<=1.
  - Otherwise: out_valid<=0, out_data holds.
- Latency: FIFO empty and no stall gives 1 cycle (in_valid at edge N, out_valid at edge N+1).
- Enqueue: in_valid=1 and the beat is not bypassed.
  - Allowed if FIFO not full, or if a dequeue occurs in the same cycle (full with simultaneous deq keeps count = DEPTH).
  - Otherwise the beat is dropped and drop=1 for the next cycle.
- Order: strict FIFO. An input beat never overtakes buffered entries; bypass happens only when the FIFO is empty.
- Occupancy update per cycle: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Pointers wrap modulo DEPTH. Full/empty are derived from occupancy (0 = empty, DEPTH = full), never from pointer equality alone.
- out_stall = (occupancy >= STALL_THRESH). It is combinational from registered occupancy only, with no path from in_* to out_stall.
- Flush (synchronous, has priority over all other activity):
  - Next cycle: out_valid=0, out_data=0, occupancy=0, pointers reset, out_flush=1, drop=0.
  - in_valid on the flush cycle is discarded without a drop pulse.
  - in_stall is ignored on the flush cycle.
  - out_flush=0 on every non-flush cycle.
  - Back-to-back flushes hold out_flush=1.
- Stalled-and-idle case: when out_valid=0, in_stall has no effect (an empty output register always advances).

Test Plan:
- Streaming (WIDTH=32, DEPTH=4): in_valid=1 with data 0x10,0x11,0x12 on consecutive cycles, in_stall=0 -> out_data 0x10,0x11,0x12 one cycle later each; occupancy stays 0; out_stall=0.
- Stall fill: out_valid=1 holding 0xA0, in_stall=1, send 0xA1..0xA4 -> occupancy 1,2,3,4; out_stall rises on the cycle occupancy reaches 3; out_data holds 0xA0. Release in_stall -> outputs 0xA1,0xA2,0xA3,0xA4 in order.
- Overflow: FIFO full (4), in_stall=1, send 0xB5 -> drop=1 for one cycle, occupancy stays 4, 0xB5 never appears at the output.
- Full with simultaneous enq/deq: occupancy=4, in_stall falls while 0xC9 arrives -> head dequeued, 0xC9 enqueued, occupancy stays 4, drop=0; 0xC9 emerges last.
- Flush mid-burst: occupancy=2, out_valid=1, assert in_flush with in_valid=1 data 0xDD -> next cycle out_flush=1, out_valid=0, out_data=0, occupancy=0, drop=0. The following cycle out_flush=0 and 0xDD never appears.
- Async reset mid-operation: assert reset between clock edges with occupancy=3 -> all outputs 0 immediately. After release, send 0xE0 -> out_data=0xE0 one cycle later.

Source files
------------

// File: rtl/pipeline_stage_fifo.sv
// Pipeline stage with a registered output and a DEPTH-entry in-order skid FIFO.
// Absorbs bursts under downstream stall, raises an early upstream stall and propagates flush.
module pipeline_stage_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_flush,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_stall,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic                         out_flush,
    output logic                         out_stall,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic adv;
    logic fifo_empty;
    logic fifo_full;
    logic deq;
    logic bypass;
    logic enq_req;
    logic enq;
    logic overflow;

    // Datapath decisions; full/empty come from the count, not pointer equality
    always_comb begin
        adv        = !(out_valid && in_stall);
        fifo_empty = (occupancy == '0);
        fifo_full  = (occupancy == OCC_W'(DEPTH));
        deq        = adv && !fifo_empty;
        bypass     = adv && fifo_empty && in_valid;
        enq_req    = in_valid && !bypass;
        enq        = enq_req && (!fifo_full || deq);
        overflow   = enq_req && !enq;
    end

    // Early stall depends only on the registered count
    assign out_stall = (occupancy >= OCC_W'(STALL_THRESH));

    // Storage needs no reset: validity is tracked by the count
    always_ff @(posedge clk) begin
        if (!in_flush && enq) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_flush <= 1'b0;
            drop      <= 1'b0;
            occupancy <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (in_flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_flush <= 1'b1;
            drop      <= 1'b0;
            occupancy <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            out_flush <= 1'b0;
            drop      <= overflow;
            if (adv) begin
                if (deq) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (bypass) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stage_fifo.sv
// Self-checking bench for pipeline_stage_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the stage.
module tb_pipeline_stage_fifo;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned THRESH = DEPTH - 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned VEC_W  = 4 + OCC_W + WIDTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_flush = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_stall = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_flush;
    logic              out_stall;
    logic [OCC_W-1:0]  occupancy;
    logic              drop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    pipeline_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .in_flush(in_flush), .in_data(in_data),
        .in_valid(in_valid), .in_stall(in_stall), .out_data(out_data),
        .out_valid(out_valid), .out_flush(out_flush), .out_stall(out_stall),
        .occupancy(occupancy), .drop(drop)
    );

    always #5 clk = ~clk;

    // Reference model: output register plus a queue of buffered beats
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;
    logic             m_flush = 1'b0;
    logic             m_drop  = 1'b0;

    task automatic model_reset();
        q.delete();
        m_data = '0; m_valid = 1'b0; m_flush = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_clk(input logic f, input logic v, input logic [WIDTH-1:0] d, input logic s);
        if (f) begin
            model_reset();
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            m_drop  = 1'b0;
            if (!(m_valid && s)) begin
                if (q.size() > 0) begin
                    m_data = q.pop_front();
                    m_valid = 1'b1;
                    if (v) q.push_back(d);
                end else if (v) begin
                    m_data = d;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end else if (v) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_drop = 1'b1;
            end
        end
    endtask

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_valid, m_flush, m_drop, (q.size() >= THRESH), OCC_W'(q.size()), m_data};
    endfunction

    function automatic logic [VEC_W-1:0] act_vec();
        return {out_valid, out_flush, drop, out_stall, occupancy, out_data};
    endfunction

    // One clock: drive at negedge, model at posedge, return at the next negedge
    task automatic cycle(input logic f, input logic v, input logic [WIDTH-1:0] d, input logic s);
        in_flush = f; in_valid = v; in_data = d; in_stall = s;
        @(posedge clk);
        model_clk(f, v, d, s);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", act_vec(), exp_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] seq [3];
        seq[0] = 32'h10; seq[1] = 32'h11; seq[2] = 32'h12;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cycle(1'b0, 1'b1, seq[i], 1'b0);
            else       cycle(1'b0, 1'b0, '0, 1'b0);
            n_tests++;
            if (act_vec() !== exp_vec() || (i < 3 && out_data !== seq[i])) begin
                n_fail++;
                $display("FAIL streaming beat %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    // Fill under stall, overflow, full enq+deq, then drain
    task automatic test_stall_fill();
        logic [WIDTH-1:0] vals [7];
        logic             stl  [7];
        vals[0] = 32'hA0; vals[1] = 32'hA1; vals[2] = 32'hA2; vals[3] = 32'hA3;
        vals[4] = 32'hA4; vals[5] = 32'hB5; vals[6] = 32'hC9;
        stl[0] = 1'b0; stl[1] = 1'b1; stl[2] = 1'b1; stl[3] = 1'b1;
        stl[4] = 1'b1; stl[5] = 1'b1; stl[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, vals[i], stl[i]);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall_fill step %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            n_tests++;
            if (act_vec() !== exp_vec() || out_data === 32'hB5) begin
                n_fail++;
                $display("FAIL drain step %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b1, 32'hD0, 1'b0);
        cycle(1'b0, 1'b1, 32'hD1, 1'b1);
        cycle(1'b0, 1'b1, 32'hD2, 1'b1);
        n_tests++;
        if (occupancy !== OCC_W'(2) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got occ %0d valid %b expected occ 2 valid 1", occupancy, out_valid);
        end
        cycle(1'b1, 1'b1, 32'hDD, 1'b1);
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush: got %h expected %h", act_vec(), exp_vec());
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush_b2b: got %h expected %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            n_tests++;
            if (act_vec() !== exp_vec() || out_data === 32'hDD) begin
                n_fail++;
                $display("FAIL post_flush %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic             f, v, s;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 70);
            s = ($urandom_range(0, 99) < 55);
            d = $urandom;
            cycle(f, v, d, s);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'hF0, 1'b0);
        cycle(1'b0, 1'b1, 32'hF1, 1'b1);
        cycle(1'b0, 1'b1, 32'hF2, 1'b1);
        cycle(1'b0, 1'b1, 32'hF3, 1'b1);
        n_tests++;
        if (occupancy !== OCC_W'(3)) begin
            n_fail++;
            $display("FAIL async_reset_setup: got occ %0d expected 3", occupancy);
        end
        in_valid = 1'b0; in_stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), exp_vec());
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 32'hE0, 1'b0);
        n_tests++;
        if (act_vec() !== exp_vec() || out_data !== 32'hE0) begin
            n_fail++;
            $display("FAIL after_reset: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
